flash_scheduler: RTL

- Round-robin scheduler that shares one bound_flasher lamp bar among NREQ requesters.
- Grants one requester at a time and drives the flasher's flick input to start a sequence.
- Watches the lamps bus to detect that the sequence has started and finished, then releases the bar to the next requester.
- A timeout prevents a stuck flasher from hanging the bar.

---
 rtl/flash_scheduler.sv | 128 ++++++++++++
 1 files changed

// File: rtl/flash_scheduler.sv
// flash_scheduler: round-robin owner of one shared bound_flasher lamp bar.
// Optional FLASH_SCHED_STATS_EN adds saturating per-requester done counters and a timeout counter.
module flash_scheduler #(
    parameter int NREQ    = 4,
    parameter int LAMP_W  = 16,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic              flick,
    input  logic [LAMP_W-1:0] lamps,
    output logic              busy,
    output logic              to_err
`ifdef FLASH_SCHED_STATS_EN
    ,
    output logic [NREQ*8-1:0] grant_cnt,
    output logic [7:0]        to_cnt
`endif
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   rr_ptr, rr_nxt, cur, cur_nxt, win;
    logic [TO_W-1:0] timer, timer_nxt;
    logic [NREQ-1:0] grant_nxt, done_nxt;
    logic            quiet, quiet_nxt, flick_nxt, to_err_nxt, lit, expire;

    assign lit    = |lamps;
    assign expire = timer == TO_W'(TIMEOUT - 2);

    // Scan downward so the requester closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        win = rr_ptr;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req[(int'(rr_ptr) + k) % NREQ]) win = PW'((int'(rr_ptr) + k) % NREQ);
    end

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        done_nxt   = '0;
        flick_nxt  = 1'b0;
        to_err_nxt = 1'b0;
        timer_nxt  = timer + TO_W'(1);
        quiet_nxt  = 1'b0;
        cur_nxt    = cur;
        rr_nxt     = rr_ptr;
        case (state)
            IDLE: begin
                timer_nxt = '0;
                if (|req) begin
                    state_nxt = START;
                    grant_nxt = NREQ'(1) << win;
                    flick_nxt = 1'b1;
                    cur_nxt   = win;
                end
            end
            START:
                if (lit) begin
                    state_nxt = RUN;
                    timer_nxt = '0;
                end else if (expire) begin
                    state_nxt  = DONE;
                    to_err_nxt = 1'b1;
                end else flick_nxt = 1'b1;
            // Two zero samples in a row are needed: one all-off cycle is just a phase gap.
            RUN:
                if (!lit && quiet) state_nxt = DONE;
                else if (expire) begin
                    state_nxt  = DONE;
                    to_err_nxt = 1'b1;
                end else quiet_nxt = !lit;
            DONE: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
        if (state_nxt == DONE && state != DONE) begin
            done_nxt  = grant;
            grant_nxt = '0;
            rr_nxt    = (cur == PW'(NREQ - 1)) ? '0 : cur + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state  <= IDLE;
            grant  <= '0;
            done   <= '0;
            flick  <= 1'b0;
            busy   <= 1'b0;
            to_err <= 1'b0;
            timer  <= '0;
            quiet  <= 1'b0;
            cur    <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            done   <= done_nxt;
            flick  <= flick_nxt;
            busy   <= state_nxt != IDLE;
            to_err <= to_err_nxt;
            timer  <= timer_nxt;
            quiet  <= quiet_nxt;
            cur    <= cur_nxt;
            rr_ptr <= rr_nxt;
        end

`ifdef FLASH_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            grant_cnt <= '0;
            to_cnt    <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (done_nxt[i] && grant_cnt[8*i +: 8] != 8'hff)
                    grant_cnt[8*i +: 8] <= grant_cnt[8*i +: 8] + 8'd1;
            if (to_err_nxt && to_cnt != 8'hff) to_cnt <= to_cnt + 8'd1;
        end
`endif
endmodule
